// File: rtl/comp_pipe.sv
// comp_pipe: pipelined multi-lane signed/unsigned magnitude comparator with valid/ready
// handshake and a running all-lanes-equal flag across bursts delimited by in_last.
module comp_pipe #(
    parameter int DATAWIDTH = 32,
    parameter int LANES     = 4,
    parameter int LATENCY   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*DATAWIDTH-1:0] in_a,
    input  logic [LANES*DATAWIDTH-1:0] in_b,
    input  logic                       in_signed,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES-1:0]           out_gt,
    output logic [LANES-1:0]           out_lt,
    output logic [LANES-1:0]           out_eq,
    output logic                       out_all_eq,
    output logic                       out_burst_eq,
    output logic                       out_last
);
    localparam logic [DATAWIDTH-1:0] SIGN_BIT = DATAWIDTH'(1) << (DATAWIDTH - 1);
    typedef struct packed {
        logic                       v;
        logic                       s;
        logic                       last;
        logic [LANES*DATAWIDTH-1:0] a;
        logic [LANES*DATAWIDTH-1:0] b;
    } in_t;
    typedef struct packed {
        logic             v;
        logic             last;
        logic [LANES-1:0] gt;
        logic [LANES-1:0] lt;
        logic [LANES-1:0] eq;
    } st_t;
    in_t                  in_q;
    st_t                  st [LATENCY];
    st_t                  cmp;
    logic [DATAWIDTH-1:0] xa, xb;
    logic                 acc, adv;
    // flipping the sign bit turns a two's-complement compare into an unsigned one
    always_comb begin
        cmp = '0;
        xa = '0;
        xb = '0;
        cmp.v = in_q.v;
        cmp.last = in_q.last;
        for (int i = 0; i < LANES; i++) begin
            xa = in_q.a[i*DATAWIDTH +: DATAWIDTH] ^ (in_q.s ? SIGN_BIT : '0);
            xb = in_q.b[i*DATAWIDTH +: DATAWIDTH] ^ (in_q.s ? SIGN_BIT : '0);
            cmp.gt[i] = xa > xb;
            cmp.lt[i] = xa < xb;
            cmp.eq[i] = xa == xb;
        end
    end
    assign adv          = !(st[LATENCY-1].v && !out_ready);
    assign in_ready     = !rst && adv;
    assign out_valid    = st[LATENCY-1].v;
    assign out_gt       = st[LATENCY-1].gt;
    assign out_lt       = st[LATENCY-1].lt;
    assign out_eq       = st[LATENCY-1].eq;
    assign out_last     = st[LATENCY-1].last;
    assign out_all_eq   = &st[LATENCY-1].eq;
    assign out_burst_eq = acc & out_all_eq;
    // bubbles only move valid bits, so every stage keeps the last real beat it saw
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q <= '0;
            for (int k = 0; k < LATENCY; k++) st[k] <= '0;
            acc <= 1'b1;
        end else if (adv) begin
            in_q.v <= in_valid;
            if (in_valid) {in_q.s, in_q.last, in_q.a, in_q.b} <= {in_signed, in_last, in_a, in_b};
            st[0].v <= in_q.v;
            if (in_q.v) st[0] <= cmp;
            for (int k = 1; k < LATENCY; k++) begin
                st[k].v <= st[k-1].v;
                if (st[k-1].v) st[k] <= st[k-1];
            end
            if (out_valid) acc <= out_last ? 1'b1 : out_burst_eq;
        end
    end
endmodule
